// File: rtl/data_memory_responder.sv
// Word-organised data memory that answers CPU load/store requests over a req/ready handshake.
// It inserts a fixed number of wait states and returns an error response for misaligned or out-of-range accesses.
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_en,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              count;
    logic [3:0]              count_next;
    logic                    accept;
    logic                    fault_in;
    logic                    wr_q;
    logic                    fault_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;
    logic [31:0]             mem [DEPTH];

    assign accept   = (state == ST_IDLE) && mem_req;
    assign fault_in = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (ADDR_WIDTH + 2)) != '0);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    state_next = (WAIT_STATES == 0) ? ST_RESPOND : ST_WAIT;
                    count_next = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (count == 4'd0) begin
                    state_next = ST_RESPOND;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Response outputs are registered on the edge leaving RESPOND, so the
    // ready cycle itself is spent back in IDLE and can overlap a new accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            wr_q      <= 1'b0;
            fault_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                wr_q    <= mem_write;
                fault_q <= fault_in;
                idx_q   <= mem_addr[ADDR_WIDTH+1:2];
                wdata_q <= mem_wdata;
                be_q    <= mem_byte_en;
            end
            mem_ready <= (state == ST_RESPOND);
            mem_error <= (state == ST_RESPOND) && fault_q;
            mem_rdata <= ((state == ST_RESPOND) && !wr_q && !fault_q) ? mem[idx_q] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if ((state == ST_RESPOND) && wr_q && !fault_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory; a second instance covers the zero-wait build.
module tb_data_memory_responder;

    localparam int unsigned WS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        error;

    logic        req0 = 1'b0;
    logic        ready0;
    logic [31:0] rdata0;
    logic        error0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] ref_bytes [1024];

    always #5 clock = ~clock;

    data_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset(reset), .mem_req(req), .mem_write(write),
        .mem_addr(addr), .mem_wdata(wdata), .mem_byte_en(be),
        .mem_ready(ready), .mem_rdata(rdata), .mem_error(error)
    );

    data_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .mem_req(req0), .mem_write(1'b0),
        .mem_addr(32'h0000_0040), .mem_wdata(32'h0), .mem_byte_en(4'h0),
        .mem_ready(ready0), .mem_rdata(rdata0), .mem_error(error0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a);
        return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[i]) ref_bytes[a + i] = d[8*i +: 8];
    endtask

    // One complete transaction; inputs other than req are scrambled while waiting.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        bit          flt;
        bit          got;
        bit          quiet;
        int unsigned lat;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        er;
        flt    = ref_fault(a);
        exp_rd = (wr || flt) ? 32'h0 : ref_load(a);
        @(negedge clock);
        req = 1'b1; write = wr; addr = a; wdata = d; be = en;
        @(posedge clock);
        got = 1'b0; quiet = 1'b1; lat = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clock);
            if (ready) begin
                got = 1'b1; lat = k; rd = rdata; er = error;
                req = 1'b0;
            end else begin
                if (rdata != 32'h0 || error) quiet = 1'b0;
                write = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
                be = 4'($urandom_range(0, 15));
            end
        end
        if (!got) begin
            check_eq("ready_timeout", 32'h0, 32'h1);
            req = 1'b0;
        end else begin
            check_eq("latency", 32'(lat), 32'(WS + 2));
            check_eq("rdata", rd, exp_rd);
            check_eq("error", 32'(er), 32'(flt));
            check_eq("quiet_while_waiting", 32'(quiet), 32'h1);
            if (wr && !flt) ref_store(a, d, en);
            @(negedge clock);
            check_eq("after_ready", {ready, error, 30'h0} | rdata, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] hold_exp;
        int          pulses [$];
        bit          seen;

        #1 reset = 1'b1;
        #1 check_eq("reset_outputs", {ready, error, 30'h0} | rdata, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int w = 0; w < 256; w++) txn(1'b1, 32'(w * 4), $urandom, 4'hF);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        check_eq("model_0x10_a", ref_load(32'h10), 32'hDEADBEEF);

        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        txn(1'b1, 32'h10, 32'h55555555, 4'b0000);
        txn(1'b0, 32'h10, 32'h0, 4'h0);
        check_eq("model_0x10_b", ref_load(32'h10), 32'hDEADBEAA);

        txn(1'b0, 32'h12, 32'h0, 4'h0);
        txn(1'b0, 32'h400, 32'h0, 4'h0);
        txn(1'b1, 32'h412, 32'h1, 4'hF);
        txn(1'b0, 32'h10, 32'h0, 4'h0);

        // Asynchronous reset while a load response is being presented.
        @(negedge clock);
        req = 1'b1; write = 1'b0; addr = 32'h10;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        check_eq("ready_before_reset", 32'(seen), 32'h1);
        check_eq("rdata_before_reset", rdata, 32'hDEADBEAA);
        #2 reset = 1'b1;
        #1 check_eq("async_reset_clears", {ready, error, 30'h0} | rdata, 32'h0);
        req = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Request held high across three loads.
        hold_exp = ref_load(32'h10);
        @(negedge clock);
        req = 1'b1; write = 1'b0; addr = 32'h10;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (ready) begin
                pulses.push_back(c);
                check_eq("held_rdata", rdata, hold_exp);
                if (pulses.size() == 3) req = 1'b0;
            end
        end
        check_eq("held_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check_eq("held_first", 32'(pulses[0]), 32'(WS + 2));
            check_eq("held_gap1", 32'(pulses[1] - pulses[0]), 32'(WS + 2));
            check_eq("held_gap2", 32'(pulses[2] - pulses[1]), 32'(WS + 2));
        end

        // Zero-wait build with request held high.
        pulses.delete();
        @(negedge clock);
        req0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (ready0) begin
                pulses.push_back(c);
                if (pulses.size() == 3) req0 = 1'b0;
            end
        end
        check_eq("ws0_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check_eq("ws0_first", 32'(pulses[0]), 32'd2);
            check_eq("ws0_gap1", 32'(pulses[1] - pulses[0]), 32'd2);
            check_eq("ws0_gap2", 32'(pulses[2] - pulses[1]), 32'd2);
        end

        // Store aborted by reset while waiting.
        hold_exp = ref_load(32'h20);
        @(negedge clock);
        req = 1'b1; write = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        check_eq("aborted_no_ready", 32'(seen), 32'h0);
        txn(1'b0, 32'h20, 32'h0, 4'h0);
        check_eq("model_0x20_kept", ref_load(32'h20), hold_exp);

        // Randomized traffic over a small hot region plus fault cases.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: a = (32'($urandom_range(0, 255)) * 4) + 32'($urandom_range(1, 3));
                1: begin
                    a = $urandom;
                    if (a < 32'd1024) a = a | 32'h0000_1000;
                end
                default: a = 32'($urandom_range(0, 15)) * 4;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
